// File: rtl/nebula_pkg.sv
// -----------------------------------------------------------------------------
// nebula_pkg
// Shared nebula NoC types and helpers.
//   noc_flit_t / flit_type_e  : flit format seen by routers and injectors
//   is_head_flit()            : flit opens a packet (HEAD or SINGLE)
//   is_tail_flit()            : flit closes a packet (TAIL or SINGLE)
//   INJ_STALL_LIMIT_DEFAULT   : default watchdog limit for the local injector
//   inj_arb_state_e           : local injection arbiter states
// -----------------------------------------------------------------------------
package nebula_pkg;

   typedef enum logic [1:0] {
      FLIT_HEAD   = 2'd0,
      FLIT_BODY   = 2'd1,
      FLIT_TAIL   = 2'd2,
      FLIT_SINGLE = 2'd3
   } flit_type_e;

   typedef struct packed {
      flit_type_e  flit_type;
      logic [3:0]  dest;
      logic [31:0] payload;
   } noc_flit_t;

   localparam int NOC_FLIT_W              = $bits(noc_flit_t);
   localparam int INJ_STALL_LIMIT_DEFAULT = 256;

   typedef enum logic {
      INJ_IDLE   = 1'b0,
      INJ_LOCKED = 1'b1
   } inj_arb_state_e;

   // A SINGLE flit is both the first and the last flit of its packet, so it
   // counts as a head and as a tail.
   function automatic logic is_head_flit(input noc_flit_t f);
      return (f.flit_type == FLIT_HEAD) || (f.flit_type == FLIT_SINGLE);
   endfunction

   function automatic logic is_tail_flit(input noc_flit_t f);
      return (f.flit_type == FLIT_TAIL) || (f.flit_type == FLIT_SINGLE);
   endfunction

endpackage

// File: rtl/nebula_rr_picker.sv
// -----------------------------------------------------------------------------
// nebula_rr_picker
// Combinational rotating-priority encoder. Returns the first set request at or
// after ptr, wrapping around. Also usable for router output allocation.
//   req   in  N      request vector
//   ptr   in  IW     highest-priority index
//   grant out N      one-hot grant (all zero when nothing requests)
//   idx   out IW     index of the granted request (0 when none)
//   any   out 1      at least one request present
// -----------------------------------------------------------------------------
module nebula_rr_picker #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   // cand_idx[k] is the requester with the k-th highest priority this cycle.
   logic [IW-1:0] cand_idx [N];

   for (genvar gi = 0; gi < N; gi++) begin : g_cand
      assign cand_idx[gi] = IW'((int'(ptr) + gi) % N);
   end

   always_comb begin
      idx = '0;
      any = |req;
      // Scan from lowest priority to highest so the highest-priority hit is
      // the one left in idx.
      for (int off = N - 1; off >= 0; off--) begin
         if (req[cand_idx[off]]) begin
            idx = cand_idx[off];
         end
      end
      grant = any ? (N'(1) << idx) : '0;
   end

endmodule

// File: rtl/nebula_local_inject_arb.sv
// -----------------------------------------------------------------------------
// nebula_local_inject_arb
// Packet-atomic round-robin arbiter for the local injection port of a
// nebula_router. NUM_REQ on-node requesters share one registered output slot;
// a grant taken on a HEAD flit stays with its owner until the TAIL is
// accepted, so packets never interleave.
//
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   req_valid    per-requester flit valid
//   req_flit     per-requester flit
//   req_ready    per-requester accept (combinational)
//   out_valid    flit valid to router local input (registered)
//   out_flit     flit to router local input (registered)
//   out_ready    router local input ready
//   busy         grant is locked to one requester
//   grant_id     current or last owner
//   orphan_err   sticky: BODY/TAIL dropped while no packet was open
//   stall_err    sticky: locked owner idle for STALL_LIMIT cycles
//   flit_cnt     per-requester accepted-flit counters
//
// Build option: define NEBULA_INJ_STATS_EN to include the saturating
// per-requester flit counters; otherwise flit_cnt is tied to zero.
// -----------------------------------------------------------------------------
module nebula_local_inject_arb
   import nebula_pkg::*;
#(
   parameter  int NUM_REQ     = 4,
   parameter  int STALL_LIMIT = INJ_STALL_LIMIT_DEFAULT,
   parameter  int CNT_W       = 16,
   localparam int IDW         = $clog2(NUM_REQ)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  noc_flit_t [NUM_REQ-1:0]         req_flit,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic                            out_valid,
   output noc_flit_t                       out_flit,
   input  logic                            out_ready,
   output logic                            busy,
   output logic [IDW-1:0]                  grant_id,
   output logic                            orphan_err,
   output logic                            stall_err,
   output logic [NUM_REQ-1:0][CNT_W-1:0]   flit_cnt
);

   localparam int WD_W = $clog2(STALL_LIMIT + 1);

   inj_arb_state_e   state_reg, state_next;
   logic [IDW-1:0]   rr_ptr_reg, rr_ptr_next;
   logic [IDW-1:0]   grant_id_reg, grant_id_next;
   logic             out_valid_reg;
   noc_flit_t        out_flit_reg;
   logic             orphan_err_reg;
   logic             stall_err_reg;
   logic [WD_W-1:0]  wd_cnt_reg;

   logic [NUM_REQ-1:0] head_req;
   logic [NUM_REQ-1:0] orphan_req;
   logic [NUM_REQ-1:0] orphan_onehot;
   logic [NUM_REQ-1:0] head_grant;
   logic [IDW-1:0]     head_idx;
   logic               head_any;

   logic               slot_free;
   logic               xfer;
   logic [IDW-1:0]     xfer_idx;
   logic               drop;

   // Split valid requests into packet openers and stray continuation flits.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_classify
      assign head_req[gi]   = req_valid[gi] &&  is_head_flit(req_flit[gi]);
      assign orphan_req[gi] = req_valid[gi] && !is_head_flit(req_flit[gi]);
   end

   // Lowest set bit of orphan_req (x & -x).
   assign orphan_onehot = orphan_req & (~orphan_req + NUM_REQ'(1));

   nebula_rr_picker #(
      .N (NUM_REQ)
   ) u_head_pick (
      .req   (head_req),
      .ptr   (rr_ptr_reg),
      .grant (head_grant),
      .idx   (head_idx),
      .any   (head_any)
   );

   // The slot can take a new flit if it is empty or is draining this cycle.
   assign slot_free = !out_valid_reg || out_ready;

   always_comb begin
      state_next    = state_reg;
      rr_ptr_next   = rr_ptr_reg;
      grant_id_next = grant_id_reg;
      req_ready     = '0;
      xfer          = 1'b0;
      xfer_idx      = grant_id_reg;
      drop          = 1'b0;

      case (state_reg)
         INJ_IDLE: begin
            if (head_any) begin
               // Openers wait for the slot; they are never dropped.
               if (slot_free) begin
                  req_ready     = head_grant;
                  xfer          = 1'b1;
                  xfer_idx      = head_idx;
                  grant_id_next = head_idx;
                  rr_ptr_next   = (head_idx == IDW'(NUM_REQ - 1)) ? '0
                                                                  : head_idx + IDW'(1);
                  if (req_flit[head_idx].flit_type == FLIT_HEAD) begin
                     state_next = INJ_LOCKED;
                  end
               end
            end else if (|orphan_req) begin
               // A stray BODY/TAIL would block its requester forever; swallow
               // it without touching the slot and flag it.
               req_ready = orphan_onehot;
               drop      = 1'b1;
            end
         end

         INJ_LOCKED: begin
            if (slot_free) begin
               req_ready[grant_id_reg] = 1'b1;
               if (req_valid[grant_id_reg]) begin
                  xfer = 1'b1;
                  // Only TAIL closes the packet; an owner's HEAD/SINGLE is
                  // forwarded as data.
                  if (req_flit[grant_id_reg].flit_type == FLIT_TAIL) begin
                     state_next = INJ_IDLE;
                  end
               end
            end
         end

         default: begin
            state_next = INJ_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= INJ_IDLE;
         rr_ptr_reg     <= '0;
         grant_id_reg   <= '0;
         out_valid_reg  <= 1'b0;
         out_flit_reg   <= '0;
         orphan_err_reg <= 1'b0;
         stall_err_reg  <= 1'b0;
         wd_cnt_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         rr_ptr_reg   <= rr_ptr_next;
         grant_id_reg <= grant_id_next;

         // out_flit only changes on a transfer, and a transfer needs a free
         // slot, so the flit is held while the router back-pressures.
         if (xfer) begin
            out_valid_reg <= 1'b1;
            out_flit_reg  <= req_flit[xfer_idx];
         end else if (out_ready) begin
            out_valid_reg <= 1'b0;
         end

         if (drop) begin
            orphan_err_reg <= 1'b1;
         end

         // Watchdog: held at zero outside LOCKED so it starts from zero on
         // entry; saturates at the limit and only raises a flag.
         if ((state_reg != INJ_LOCKED) || xfer) begin
            wd_cnt_reg <= '0;
         end else if (wd_cnt_reg == WD_W'(STALL_LIMIT - 1)) begin
            stall_err_reg <= 1'b1;
         end else begin
            wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
         end
      end
   end

   assign out_valid  = out_valid_reg;
   assign out_flit   = out_flit_reg;
   assign busy       = (state_reg == INJ_LOCKED);
   assign grant_id   = grant_id_reg;
   assign orphan_err = orphan_err_reg;
   assign stall_err  = stall_err_reg;

`ifdef NEBULA_INJ_STATS_EN
   logic [NUM_REQ-1:0][CNT_W-1:0] flit_cnt_reg;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            flit_cnt_reg[gi] <= '0;
         end else if (xfer && (xfer_idx == IDW'(gi)) && (flit_cnt_reg[gi] != '1)) begin
            flit_cnt_reg[gi] <= flit_cnt_reg[gi] + CNT_W'(1);
         end
      end
   end

   assign flit_cnt = flit_cnt_reg;
`else
   assign flit_cnt = '0;
`endif

endmodule

// File: tb/tb_nebula_local_inject_arb.sv
// -----------------------------------------------------------------------------
// tb_nebula_local_inject_arb
// Directed bench for nebula_local_inject_arb (NUM_REQ=4, STALL_LIMIT=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// or 1 unit later (combinational req_ready).
// -----------------------------------------------------------------------------
module tb_nebula_local_inject_arb;
   import nebula_pkg::*;

   localparam int NR = 4;
   localparam int SL = 8;
   localparam int CW = 16;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NR-1:0]         req_valid;
   noc_flit_t [NR-1:0]    req_flit;
   logic [NR-1:0]         req_ready;
   logic                  out_valid;
   noc_flit_t             out_flit;
   logic                  out_ready;
   logic                  busy;
   logic [1:0]            grant_id;
   logic                  orphan_err;
   logic                  stall_err;
   logic [NR-1:0][CW-1:0] flit_cnt;

   int checks_cnt = 0;
   int fail_cnt   = 0;

   nebula_local_inject_arb #(
      .NUM_REQ     (NR),
      .STALL_LIMIT (SL),
      .CNT_W       (CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_flit   (req_flit),
      .req_ready  (req_ready),
      .out_valid  (out_valid),
      .out_flit   (out_flit),
      .out_ready  (out_ready),
      .busy       (busy),
      .grant_id   (grant_id),
      .orphan_err (orphan_err),
      .stall_err  (stall_err),
      .flit_cnt   (flit_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   function automatic noc_flit_t mk(input flit_type_e t, input logic [31:0] p);
      noc_flit_t f;
      f.flit_type = t;
      f.dest      = 4'h0;
      f.payload   = p;
      return f;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input flit_type_e t, input logic [31:0] p);
      req_valid[i] = 1'b1;
      req_flit[i]  = mk(t, p);
   endtask

   task automatic clr_req(input int i);
      req_valid[i] = 1'b0;
      req_flit[i]  = '0;
   endtask

   task automatic clear_all();
      req_valid = '0;
      req_flit  = '0;
   endtask

   // Wait for combinational req_ready to settle, then compare it.
   task automatic chk_ready(input string tag, input logic [NR-1:0] exp);
      #1;
      check_eq(tag, 64'(req_ready), 64'(exp));
   endtask

   task automatic chk_out(input string tag, input noc_flit_t exp);
      check_eq({tag, ".valid"}, 64'(out_valid), 64'(1));
      check_eq({tag, ".flit"}, 64'(out_flit), 64'(exp));
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      out_ready = 1'b1;
      clear_all();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [CW-1:0] cnt_exp;
`ifdef NEBULA_INJ_STATS_EN
      cnt_exp = CW'(3);
`else
      cnt_exp = '0;
`endif
      do_reset();

      // ---------------- reset state ----------------
      check_eq("rst.out_valid", 64'(out_valid), 64'(0));
      check_eq("rst.out_flit", 64'(out_flit), 64'(0));
      check_eq("rst.busy", 64'(busy), 64'(0));
      check_eq("rst.grant_id", 64'(grant_id), 64'(0));
      check_eq("rst.orphan", 64'(orphan_err), 64'(0));
      check_eq("rst.stall", 64'(stall_err), 64'(0));
      check_eq("rst.ready", 64'(req_ready), 64'(0));

      // ---------------- T1: req0 HEAD, BODY, TAIL ----------------
      set_req(0, FLIT_HEAD, 32'h100);
      chk_ready("t1.c0.ready", 4'b0001);
      tick();
      chk_out("t1.c1", mk(FLIT_HEAD, 32'h100));
      check_eq("t1.c1.busy", 64'(busy), 64'(1));
      check_eq("t1.c1.grant", 64'(grant_id), 64'(0));
      set_req(0, FLIT_BODY, 32'h101);
      chk_ready("t1.c1.ready", 4'b0001);
      tick();
      chk_out("t1.c2", mk(FLIT_BODY, 32'h101));
      check_eq("t1.c2.busy", 64'(busy), 64'(1));
      set_req(0, FLIT_TAIL, 32'h102);
      chk_ready("t1.c2.ready", 4'b0001);
      tick();
      chk_out("t1.c3", mk(FLIT_TAIL, 32'h102));
      clr_req(0);
      tick();
      check_eq("t1.c4.out_valid", 64'(out_valid), 64'(0));
      check_eq("t1.c4.busy", 64'(busy), 64'(0));
      check_eq("t1.c4.grant", 64'(grant_id), 64'(0));
      check_eq("t1.flit_cnt0", 64'(flit_cnt[0]), 64'(cnt_exp));

      // ---------------- T2: req0 and req2 contend, rr_ptr=0 ----------------
      do_reset();
      set_req(0, FLIT_HEAD, 32'hA0);
      set_req(2, FLIT_HEAD, 32'hC0);
      chk_ready("t2.c0.ready", 4'b0001);
      tick();
      chk_out("t2.c1", mk(FLIT_HEAD, 32'hA0));
      check_eq("t2.c1.grant", 64'(grant_id), 64'(0));
      for (int k = 1; k <= 3; k++) begin
         set_req(0, (k == 3) ? FLIT_TAIL : FLIT_BODY, 32'hA0 + 32'(k));
         chk_ready($sformatf("t2.a%0d.ready", k), 4'b0001);
         tick();
         chk_out($sformatf("t2.a%0d", k), mk((k == 3) ? FLIT_TAIL : FLIT_BODY, 32'hA0 + 32'(k)));
      end
      clr_req(0);
      check_eq("t2.c4.busy", 64'(busy), 64'(0));
      chk_ready("t2.c4.ready", 4'b0100);
      tick();
      chk_out("t2.c5", mk(FLIT_HEAD, 32'hC0));
      check_eq("t2.c5.grant", 64'(grant_id), 64'(2));
      check_eq("t2.c5.busy", 64'(busy), 64'(1));
      for (int k = 1; k <= 3; k++) begin
         set_req(2, (k == 3) ? FLIT_TAIL : FLIT_BODY, 32'hC0 + 32'(k));
         chk_ready($sformatf("t2.c%0d.ready", k), 4'b0100);
         tick();
         chk_out($sformatf("t2.c%0d", k), mk((k == 3) ? FLIT_TAIL : FLIT_BODY, 32'hC0 + 32'(k)));
      end
      // rr_ptr should now be 3: req3 beats req0 for two SINGLEs.
      clr_req(2);
      set_req(0, FLIT_SINGLE, 32'hA9);
      set_req(3, FLIT_SINGLE, 32'hD9);
      chk_ready("t2.ptr3.ready", 4'b1000);
      tick();
      chk_out("t2.s3", mk(FLIT_SINGLE, 32'hD9));
      check_eq("t2.s3.grant", 64'(grant_id), 64'(3));
      check_eq("t2.s3.busy", 64'(busy), 64'(0));
      clr_req(3);
      chk_ready("t2.ptr0.ready", 4'b0001);
      tick();
      chk_out("t2.s0", mk(FLIT_SINGLE, 32'hA9));
      check_eq("t2.s0.grant", 64'(grant_id), 64'(0));
      clear_all();
      tick();
      check_eq("t2.end.out_valid", 64'(out_valid), 64'(0));

      // ---------------- T3: back-pressure while locked on req1 ----------------
      do_reset();
      set_req(1, FLIT_HEAD, 32'h300);
      chk_ready("t3.c0.ready", 4'b0010);
      tick();
      chk_out("t3.c1", mk(FLIT_HEAD, 32'h300));
      check_eq("t3.c1.grant", 64'(grant_id), 64'(1));
      set_req(1, FLIT_BODY, 32'h301);
      out_ready = 1'b0;
      #1;
      for (int k = 0; k < 5; k++) begin
         check_eq($sformatf("t3.hold%0d.ready", k), 64'(req_ready), 64'(0));
         tick();
         chk_out($sformatf("t3.hold%0d", k), mk(FLIT_HEAD, 32'h300));
      end
      out_ready = 1'b1;
      chk_ready("t3.rel.ready", 4'b0010);
      tick();
      chk_out("t3.rel", mk(FLIT_BODY, 32'h301));
      set_req(1, FLIT_TAIL, 32'h302);
      chk_ready("t3.tail.ready", 4'b0010);
      tick();
      chk_out("t3.tail", mk(FLIT_TAIL, 32'h302));
      check_eq("t3.tail.busy", 64'(busy), 64'(0));
      check_eq("t3.orphan", 64'(orphan_err), 64'(0));
      clear_all();
      tick();

      // ---------------- T4: orphan BODY from req3 while IDLE ----------------
      set_req(3, FLIT_BODY, 32'h400);
      chk_ready("t4.ready", 4'b1000);
      tick();
      clear_all();
      check_eq("t4.orphan", 64'(orphan_err), 64'(1));
      check_eq("t4.out_valid", 64'(out_valid), 64'(0));
      tick();
      check_eq("t4.orphan_sticky", 64'(orphan_err), 64'(1));
      check_eq("t4.out_valid2", 64'(out_valid), 64'(0));

      // ---------------- T5: stall watchdog ----------------
      do_reset();
      check_eq("t5.orphan_clr", 64'(orphan_err), 64'(0));
      set_req(0, FLIT_HEAD, 32'h500);
      chk_ready("t5.head.ready", 4'b0001);
      tick();
      clr_req(0);
      for (int k = 1; k <= SL; k++) begin
         check_eq($sformatf("t5.L%0d.stall", k), 64'(stall_err), 64'(0));
         check_eq($sformatf("t5.L%0d.busy", k), 64'(busy), 64'(1));
         tick();
      end
      check_eq("t5.stall_set", 64'(stall_err), 64'(1));
      check_eq("t5.busy_kept", 64'(busy), 64'(1));
      set_req(0, FLIT_TAIL, 32'h501);
      chk_ready("t5.tail.ready", 4'b0001);
      tick();
      clr_req(0);
      chk_out("t5.tail", mk(FLIT_TAIL, 32'h501));
      check_eq("t5.tail.busy", 64'(busy), 64'(0));
      check_eq("t5.stall_sticky", 64'(stall_err), 64'(1));

      // ---------------- T6: reset mid-packet ----------------
      set_req(2, FLIT_HEAD, 32'h600);
      chk_ready("t6.head.ready", 4'b0100);
      tick();
      set_req(2, FLIT_BODY, 32'h601);
      check_eq("t6.locked", 64'(busy), 64'(1));
      tick();
      rst_n = 1'b0;
      clear_all();
      tick();
      check_eq("t6.rst.out_valid", 64'(out_valid), 64'(0));
      check_eq("t6.rst.out_flit", 64'(out_flit), 64'(0));
      check_eq("t6.rst.ready", 64'(req_ready), 64'(0));
      check_eq("t6.rst.busy", 64'(busy), 64'(0));
      check_eq("t6.rst.grant", 64'(grant_id), 64'(0));
      check_eq("t6.rst.stall", 64'(stall_err), 64'(0));
      check_eq("t6.rst.orphan", 64'(orphan_err), 64'(0));
      check_eq("t6.rst.flit_cnt", 64'(flit_cnt), 64'(0));
      rst_n = 1'b1;
      set_req(2, FLIT_HEAD, 32'h610);
      chk_ready("t6.new.ready", 4'b0100);
      tick();
      chk_out("t6.new", mk(FLIT_HEAD, 32'h610));
      check_eq("t6.new.grant", 64'(grant_id), 64'(2));
      check_eq("t6.new.busy", 64'(busy), 64'(1));
      set_req(2, FLIT_BODY, 32'h611);
      tick();
      set_req(2, FLIT_TAIL, 32'h612);
      tick();
      clear_all();
      chk_out("t6.tail", mk(FLIT_TAIL, 32'h612));
      check_eq("t6.tail.busy", 64'(busy), 64'(0));
      check_eq("t6.flit_cnt2", 64'(flit_cnt[2]), 64'(cnt_exp));
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end

endmodule
